// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity frame controller.
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StCheck  = 2'd3
  } stateT;

  localparam int unsigned DATA_BITS = 4;

  localparam int unsigned EVEN = 0;
  localparam int unsigned ODD  = 1;

  // Maps the raw XOR of all frame bits to an error verdict for the given mode.
  function automatic logic parityVerdict(input logic pec, input int unsigned mode);
    return (mode == ODD) ? ~pec : pec;
  endfunction

endpackage

// File: rtl/parity_bit_checker.sv
// Combinational 4-bit parity checker: XOR of four data bits and one parity bit.
module parity_bit_checker (
  input  logic inA,
  input  logic inB,
  input  logic inC,
  input  logic inD,
  input  logic inP,
  output logic outPEC
);

  assign outPEC = inA ^ inB ^ inC ^ inD ^ inP;

endmodule

// File: rtl/parity_frame_controller.sv
// Collects a serial D3..D0,P frame, checks it with parity_bit_checker and
// registers the verdict, the data nibble and a saturating error count.
module parity_frame_controller
  import parity_pkg::*;
#(
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inStart,
  input  logic                 inValid,
  input  logic                 inSerial,
  input  logic                 inClrCnt,
  output logic                 outBusy,
  output logic                 outDone,
  output logic                 outErr,
  output logic                 outAbort,
  output logic [DATA_BITS-1:0] outData,
  output logic [CNT_W-1:0]     outErrCount
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  stateT                stateQ, stateD;
  logic [1:0]           bitIdxQ, bitIdxD;
  logic [DATA_BITS-1:0] shiftQ, shiftD;
  logic                 parityQ, parityD;

  logic                 busyD, doneD, errD, abortD;
  logic [DATA_BITS-1:0] dataD;
  logic [CNT_W-1:0]     cntD;

  logic collecting;
  logic restart;
  logic pec;
  logic verdict;

  assign collecting = (stateQ == StShift) || (stateQ == StParity);
  // A restart takes priority over the bit offered in the same cycle.
  assign restart    = inStart && collecting;

  parity_bit_checker uChecker (
    .inA    (shiftQ[3]),
    .inB    (shiftQ[2]),
    .inC    (shiftQ[1]),
    .inD    (shiftQ[0]),
    .inP    (parityQ),
    .outPEC (pec)
  );

  assign verdict = parityVerdict(pec, ODD_PARITY);

  // State and frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= StIdle;
      bitIdxQ     <= 2'd0;
      shiftQ      <= '0;
      parityQ     <= 1'b0;
      outBusy     <= 1'b0;
      outDone     <= 1'b0;
      outErr      <= 1'b0;
      outAbort    <= 1'b0;
      outData     <= '0;
      outErrCount <= '0;
    end else begin
      stateQ      <= stateD;
      bitIdxQ     <= bitIdxD;
      shiftQ      <= shiftD;
      parityQ     <= parityD;
      outBusy     <= busyD;
      outDone     <= doneD;
      outErr      <= errD;
      outAbort    <= abortD;
      outData     <= dataD;
      outErrCount <= cntD;
    end
  end

  // Next-state and frame collection.
  always_comb begin
    stateD  = stateQ;
    bitIdxD = bitIdxQ;
    shiftD  = shiftQ;
    parityD = parityQ;
    unique case (stateQ)
      StIdle: begin
        if (inStart) begin
          stateD  = StShift;
          bitIdxD = 2'd0;
          shiftD  = '0;
          parityD = 1'b0;
        end
      end
      StShift: begin
        if (restart) begin
          bitIdxD = 2'd0;
          shiftD  = '0;
          parityD = 1'b0;
        end else if (inValid) begin
          shiftD  = {shiftQ[DATA_BITS-2:0], inSerial};
          bitIdxD = bitIdxQ + 2'd1;
          if (bitIdxQ == 2'd3) begin
            stateD = StParity;
          end
        end
      end
      StParity: begin
        if (restart) begin
          stateD  = StShift;
          bitIdxD = 2'd0;
          shiftD  = '0;
          parityD = 1'b0;
        end else if (inValid) begin
          parityD = inSerial;
          stateD  = StCheck;
        end
      end
      StCheck: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // Output register next values.
  always_comb begin
    busyD  = (stateD != StIdle);
    doneD  = (stateQ == StCheck);
    abortD = restart;
    errD   = outErr;
    dataD  = outData;
    cntD   = outErrCount;
    if (stateQ == StCheck) begin
      errD  = verdict;
      dataD = shiftQ;
      if (verdict && (outErrCount != CntMax)) begin
        cntD = outErrCount + CntOne;
      end
    end
    if (inClrCnt) begin
      cntD = '0;
    end
  end

endmodule

// File: tb/tb_parity_frame_controller.sv
// Directed bench for parity_frame_controller: table of frames plus corner sequences.
module tb_parity_frame_controller;

  logic clk = 1'b0;
  logic rst, inStart, inValid, inSerial, inClrCnt;

  logic       busyE, doneE, errE, abortE;
  logic [3:0] dataE;
  logic [7:0] cntE;
  logic       busyO, doneO, errO, abortO;
  logic [3:0] dataO;
  logic [7:0] cntO;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] data;
    logic       par;
    logic       expErr;
    logic [7:0] expCnt;
  } vecT;

  vecT vecs[6];

  always #5 clk = ~clk;

  parity_frame_controller #(.ODD_PARITY(0), .CNT_W(8)) dutEven (
    .clk         (clk),
    .rst         (rst),
    .inStart     (inStart),
    .inValid     (inValid),
    .inSerial    (inSerial),
    .inClrCnt    (inClrCnt),
    .outBusy     (busyE),
    .outDone     (doneE),
    .outErr      (errE),
    .outAbort    (abortE),
    .outData     (dataE),
    .outErrCount (cntE)
  );

  parity_frame_controller #(.ODD_PARITY(1), .CNT_W(8)) dutOdd (
    .clk         (clk),
    .rst         (rst),
    .inStart     (inStart),
    .inValid     (inValid),
    .inSerial    (inSerial),
    .inClrCnt    (inClrCnt),
    .outBusy     (busyO),
    .outDone     (doneO),
    .outErr      (errO),
    .outAbort    (abortO),
    .outData     (dataO),
    .outErrCount (cntO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    inValid  = 1'b1;
    inSerial = b;
    tick();
    inValid  = 1'b0;
    inSerial = 1'b0;
  endtask

  task automatic startFrame();
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
  endtask

  task automatic waitDone(inout int edges);
    int n;
    n = 0;
    while (!doneE && n < 12) begin
      tick();
      edges++;
      n++;
    end
  endtask

  // Edge count includes the edge that samples inStart.
  task automatic runFrame(input logic [3:0] data, input logic p, output int edges);
    edges = 1;
    startFrame();
    for (int i = 0; i < 4; i++) begin
      sendBit(data[3-i]);
      edges++;
    end
    sendBit(p);
    edges++;
    waitDone(edges);
    check("frame_done", doneE, 1'b1);
  endtask

  initial begin
    int edges;
    vecs[0] = '{data: 4'b1011, par: 1'b0, expErr: 1'b1, expCnt: 8'd1};
    vecs[1] = '{data: 4'b0110, par: 1'b0, expErr: 1'b0, expCnt: 8'd1};
    vecs[2] = '{data: 4'b0000, par: 1'b1, expErr: 1'b1, expCnt: 8'd2};
    vecs[3] = '{data: 4'b1111, par: 1'b0, expErr: 1'b0, expCnt: 8'd2};
    vecs[4] = '{data: 4'b1000, par: 1'b1, expErr: 1'b0, expCnt: 8'd2};
    vecs[5] = '{data: 4'b0111, par: 1'b0, expErr: 1'b1, expCnt: 8'd3};

    rst = 1'b1; inStart = 1'b0; inValid = 1'b0; inSerial = 1'b0; inClrCnt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", busyE, 1'b0);
    check("reset_done", doneE, 1'b0);
    check("reset_err", errE, 1'b0);
    check("reset_abort", abortE, 1'b0);
    check("reset_data", dataE, 4'h0);
    check("reset_count", cntE, 8'h00);

    // First good frame and its latency.
    runFrame(4'b1011, 1'b1, edges);
    check("first_edges", edges, 7);
    check("first_err", errE, 1'b0);
    check("first_data", dataE, 4'hB);
    check("first_count", cntE, 8'h00);
    check("first_busy_low", busyE, 1'b0);
    tick();
    check("done_one_cycle", doneE, 1'b0);

    for (int v = 0; v < 6; v++) begin
      runFrame(vecs[v].data, vecs[v].par, edges);
      check("vec_edges", edges, 7);
      check("vec_err", errE, vecs[v].expErr);
      check("vec_data", dataE, vecs[v].data);
      check("vec_count", cntE, vecs[v].expCnt);
    end

    // Saturation: back-to-back errored frames from a count of 3.
    for (int f = 0; f < 252; f++) runFrame(4'b1011, 1'b0, edges);
    check("count_reach_max", cntE, 8'hFF);
    for (int f = 0; f < 4; f++) runFrame(4'b1011, 1'b0, edges);
    check("count_saturated", cntE, 8'hFF);
    check("sat_err", errE, 1'b1);

    inClrCnt = 1'b1;
    tick();
    inClrCnt = 1'b0;
    check("clear_idle", cntE, 8'h00);
    runFrame(4'b1011, 1'b0, edges);
    check("count_after_clear", cntE, 8'h01);

    // Clear coinciding with an errored CHECK.
    startFrame();
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    sendBit(1'b1);
    inClrCnt = 1'b1;
    tick();
    inClrCnt = 1'b0;
    check("clr_vs_inc_done", doneE, 1'b1);
    check("clr_vs_inc_err", errE, 1'b1);
    check("clr_vs_inc_count", cntE, 8'h00);

    // Stall of 3 cycles between D1 and D0.
    tick();
    edges = 1;
    startFrame();
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
    edges += 3;
    tick(); tick(); tick();
    edges += 3;
    sendBit(1'b0);
    sendBit(1'b0);
    edges += 2;
    waitDone(edges);
    check("stall_edges", edges, 10);
    check("stall_err", errE, 1'b0);
    check("stall_data", dataE, 4'h6);

    // Restart after two data bits; the restart-cycle bit must be dropped.
    startFrame();
    sendBit(1'b1);
    sendBit(1'b0);
    inStart = 1'b1; inValid = 1'b1; inSerial = 1'b0;
    tick();
    inStart = 1'b0; inValid = 1'b0;
    check("abort_pulse", abortE, 1'b1);
    check("abort_busy", busyE, 1'b1);
    check("abort_data_held", dataE, 4'h6);
    check("abort_count_held", cntE, 8'h00);
    sendBit(1'b1);
    check("abort_single", abortE, 1'b0);
    sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
    sendBit(1'b0);
    edges = 0;
    waitDone(edges);
    check("restart_done", doneE, 1'b1);
    check("restart_data", dataE, 4'hF);
    check("restart_err", errE, 1'b0);
    check("restart_no_abort", abortE, 1'b0);

    // inStart during CHECK is ignored.
    tick();
    startFrame();
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    sendBit(1'b0);
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    check("check_start_done", doneE, 1'b1);
    check("check_start_busy", busyE, 1'b0);
    tick();
    check("check_start_idle", busyE, 1'b0);

    // Odd-parity instance.
    runFrame(4'b0000, 1'b1, edges);
    check("odd_good_err", errO, 1'b0);
    check("odd_good_done", doneO, 1'b1);
    runFrame(4'b0000, 1'b0, edges);
    check("odd_bad_err", errO, 1'b1);
    check("odd_bad_data", dataO, 4'h0);

    // Reset in the middle of PARITY.
    runFrame(4'b1011, 1'b0, edges);
    startFrame();
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", busyE, 1'b0);
    check("rst_done", doneE, 1'b0);
    check("rst_err", errE, 1'b0);
    check("rst_abort", abortE, 1'b0);
    check("rst_data", dataE, 4'h0);
    check("rst_count", cntE, 8'h00);
    sendBit(1'b1);
    check("rst_idle_ignores_valid", busyE, 1'b0);
    runFrame(4'b1011, 1'b1, edges);
    check("post_rst_edges", edges, 7);
    check("post_rst_data", dataE, 4'hB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
